// File: rtl/core_mem_arb_pkg.sv
// Shared types and defaults for the core memory arbiter slice.
package core_mem_arb_pkg;

  localparam int unsigned NUM_REQ_DEF         = 2;
  localparam int unsigned ADDR_WIDTH_DEF      = 32;
  localparam int unsigned DATA_WIDTH_DEF      = 32;
  localparam int unsigned MAX_OUTSTANDING_DEF = 2;

  typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_idx_t;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0]   addr;
    logic                        we;
    logic [DATA_WIDTH_DEF/8-1:0] be;
    logic [DATA_WIDTH_DEF-1:0]   wdata;
  } mem_req_t;

  // Next round-robin index, wrapping at n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/core_mem_arb_id_fifo.sv
// In-order FIFO holding the requester ID of every granted-but-unanswered transaction.
module core_mem_arb_id_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Storage write; contents are don't-care while empty so no reset needed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one OBI-style data port between NUM_REQ requesters.
// Responses are routed back in order via an ID FIFO.
// Optional per-requester grant counters: define CORE_MEM_ARB_PERF_EN.
module core_mem_arbiter
  import core_mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = NUM_REQ_DEF,
  parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_REQ-1:0]                  req_i,
  output logic [NUM_REQ-1:0]                  gnt_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]       addr_i,
  input  logic [NUM_REQ-1:0]                  we_i,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]   be_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       wdata_i,
  output logic [NUM_REQ-1:0]                  rvalid_o,
  output logic [DATA_WIDTH-1:0]               rdata_o,
  output logic                                mem_req_o,
  input  logic                                mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]               mem_addr_o,
  output logic                                mem_we_o,
  output logic [DATA_WIDTH/8-1:0]             mem_be_o,
  output logic [DATA_WIDTH-1:0]               mem_wdata_o,
  input  logic                                mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]               mem_rdata_i,
  output logic [NUM_REQ*32-1:0]               grant_cnt_o
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_W    = $clog2(NUM_REQ);

  logic [IDX_W-1:0] rr_ptr_q, lock_idx_q, winner, head;
  logic             lock_q, fifo_full, fifo_empty, handshake, pop;

  // Winner: locked index while a request is stalled, else first req at/after rr_ptr.
  always_comb begin
    int unsigned idx;
    logic        found;
    winner = rr_ptr_q;
    found  = 1'b0;
    idx    = 0;
    if (lock_q) begin
      winner = lock_idx_q;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        idx = (32'(rr_ptr_q) + i) % NUM_REQ;
        if (!found && req_i[idx]) begin
          winner = IDX_W'(idx);
          found  = 1'b1;
        end
      end
    end
  end

  // Reset gates the request so nothing leaks out while rst_ni is low.
  assign mem_req_o   = rst_ni & (|req_i) & ~fifo_full;
  assign handshake   = mem_req_o & mem_gnt_i;
  assign pop         = mem_rvalid_i & ~fifo_empty;
  assign rdata_o     = mem_rdata_i;
  assign mem_addr_o  = addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
  assign mem_we_o    = we_i[winner];
  assign mem_be_o    = be_i[winner*BE_WIDTH +: BE_WIDTH];
  assign mem_wdata_o = wdata_i[winner*DATA_WIDTH +: DATA_WIDTH];

  // One-hot grant and response routing.
  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    if (handshake) gnt_o[winner] = 1'b1;
    if (pop)       rvalid_o[head] = 1'b1;
  end

  // Round-robin pointer advance and address-stability lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (handshake) begin
      lock_q   <= 1'b0;
      rr_ptr_q <= IDX_W'(wrap_inc(32'(winner), NUM_REQ));
    end else if (mem_req_o) begin
      lock_q     <= 1'b1;
      lock_idx_q <= winner;
    end
  end

  core_mem_arb_id_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake),
    .data_i  (winner),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef CORE_MEM_ARB_PERF_EN
  logic [NUM_REQ*32-1:0] cnt_q;

  // Wrapping grant counter per requester.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else if (handshake) cnt_q[winner*32 +: 32] <= cnt_q[winner*32 +: 32] + 32'd1;
  end

  assign grant_cnt_o = cnt_q;
`else
  assign grant_cnt_o = '0;
`endif

`ifndef SYNTHESIS
  stray_rvalid_chk: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> !fifo_empty);
`endif

endmodule

// File: tb/tb_core_mem_arbiter.sv
module tb_core_mem_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned MO = 2;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic [NR-1:0]    req_i, gnt_o, we_i, rvalid_o;
  logic [NR*AW-1:0] addr_i;
  logic [NR*BW-1:0] be_i;
  logic [NR*DW-1:0] wdata_i;
  logic [DW-1:0]    rdata_o, mem_wdata_o, mem_rdata_i;
  logic             mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
  logic [AW-1:0]    mem_addr_o;
  logic [BW-1:0]    mem_be_o;
  logic [NR*32-1:0] grant_cnt_o;

  always #5 clk = ~clk;

  core_mem_arbiter #(
    .NUM_REQ         (NR),
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .addr_i       (addr_i),
    .we_i         (we_i),
    .be_i         (be_i),
    .wdata_i      (wdata_i),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_addr_o   (mem_addr_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .grant_cnt_o  (grant_cnt_o)
  );

  typedef struct {
    logic [1:0]  req;
    logic        mgnt;
    logic        mrv;
    logic [31:0] rdata;
    logic        exp_req;
    int unsigned exp_win;
    logic [1:0]  exp_gnt;
  } vec_t;

  vec_t        tbl[$];
  int unsigned exp_q[$];
  int unsigned exp_cnt[NR];
  int          total = 0;
  int          bad   = 0;

  function automatic vec_t mk(input logic [1:0] req, input logic g, input logic rv,
                              input logic [31:0] d, input logic er, input int unsigned w,
                              input logic [1:0] eg);
    vec_t v;
    v.req = req; v.mgnt = g; v.mrv = rv; v.rdata = d;
    v.exp_req = er; v.exp_win = w; v.exp_gnt = eg;
    return v;
  endfunction

  function automatic logic [31:0] addr_of(input int unsigned r);
    return 32'h1000 * (r + 1);
  endfunction

  function automatic logic [31:0] wdata_of(input int unsigned r);
    return 32'hD0D0_0000 | r;
  endfunction

  function automatic logic [3:0] be_of(input int unsigned r);
    return (r == 1) ? 4'h3 : 4'hF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name);
    logic [63:0] exp;
`ifdef CORE_MEM_ARB_PERF_EN
    exp = {exp_cnt[1], exp_cnt[0]};
`else
    exp = '0;
`endif
    chk(name, grant_cnt_o, exp);
  endtask

  // One cycle: drive after negedge, check combinational outputs, update scoreboard.
  task automatic apply(input vec_t v);
    logic [1:0]  exp_rv;
    int unsigned owner;
    @(negedge clk);
    req_i = v.req; mem_gnt_i = v.mgnt; mem_rvalid_i = v.mrv; mem_rdata_i = v.rdata;
    #1;
    chk("mem_req", 64'(mem_req_o), 64'(v.exp_req));
    chk("gnt", 64'(gnt_o), 64'(v.exp_gnt));
    if (v.exp_req) begin
      chk("mem_addr", 64'(mem_addr_o), 64'(addr_of(v.exp_win)));
      chk("mem_we", 64'(mem_we_o), 64'(v.exp_win == 1));
      chk("mem_be", 64'(mem_be_o), 64'(be_of(v.exp_win)));
      chk("mem_wdata", 64'(mem_wdata_o), 64'(wdata_of(v.exp_win)));
    end
    exp_rv = '0;
    if (v.mrv) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rvalid_owner: got response with rvalid_o=%0h, expected no outstanding owner", rvalid_o);
      end else begin
        owner = exp_q.pop_front();
        exp_rv[owner] = 1'b1;
      end
      chk("rdata", 64'(rdata_o), 64'(v.rdata));
    end
    chk("rvalid", 64'(rvalid_o), 64'(exp_rv));
    for (int unsigned r = 0; r < NR; r++) begin
      if (v.exp_gnt[r]) begin
        exp_q.push_back(r);
        exp_cnt[r]++;
      end
    end
  endtask

  initial begin
    rst_ni = 1'b0; req_i = 2'b11; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = '0;
    for (int unsigned r = 0; r < NR; r++) begin
      addr_i[r*AW +: AW]  = addr_of(r);
      wdata_i[r*DW +: DW] = wdata_of(r);
      be_i[r*BW +: BW]    = be_of(r);
      we_i[r]             = (r == 1);
      exp_cnt[r]          = 0;
    end

    // contention: alternating grants, response one cycle later
    tbl.push_back(mk(2'b11, 1, 0, 32'h0,      1, 0, 2'b01));
    tbl.push_back(mk(2'b11, 1, 1, 32'hA1,     1, 1, 2'b10));
    tbl.push_back(mk(2'b11, 1, 1, 32'hA2,     1, 0, 2'b01));
    tbl.push_back(mk(2'b11, 1, 1, 32'hA3,     1, 1, 2'b10));
    tbl.push_back(mk(2'b00, 0, 1, 32'hA4,     0, 0, 2'b00));
    // ordering 1 then 0, plus full stall and pop-does-not-unblock
    tbl.push_back(mk(2'b10, 1, 0, 32'h0,      1, 1, 2'b10));
    tbl.push_back(mk(2'b01, 1, 0, 32'h0,      1, 0, 2'b01));
    tbl.push_back(mk(2'b11, 1, 0, 32'h0,      0, 0, 2'b00));
    tbl.push_back(mk(2'b11, 1, 1, 32'hAAAA,   0, 0, 2'b00));
    tbl.push_back(mk(2'b11, 1, 1, 32'h5555,   1, 1, 2'b10));
    tbl.push_back(mk(2'b00, 0, 1, 32'h1234,   0, 0, 2'b00));
    // lock: requester 1 stalled, requester 0 arrives but must wait
    tbl.push_back(mk(2'b10, 0, 0, 32'h0,      1, 1, 2'b00));
    tbl.push_back(mk(2'b11, 0, 0, 32'h0,      1, 1, 2'b00));
    tbl.push_back(mk(2'b11, 0, 0, 32'h0,      1, 1, 2'b00));
    tbl.push_back(mk(2'b11, 1, 0, 32'h0,      1, 1, 2'b10));
    tbl.push_back(mk(2'b11, 1, 0, 32'h0,      1, 0, 2'b01));
    tbl.push_back(mk(2'b00, 0, 1, 32'hB1,     0, 0, 2'b00));
    tbl.push_back(mk(2'b00, 0, 1, 32'hB2,     0, 0, 2'b00));
    // single requester back-to-back until the FIFO fills
    tbl.push_back(mk(2'b01, 1, 0, 32'h0,      1, 0, 2'b01));
    tbl.push_back(mk(2'b01, 1, 0, 32'h0,      1, 0, 2'b01));
    tbl.push_back(mk(2'b01, 1, 0, 32'h0,      0, 0, 2'b00));
    tbl.push_back(mk(2'b00, 0, 1, 32'hC1,     0, 0, 2'b00));
    tbl.push_back(mk(2'b00, 0, 1, 32'hC2,     0, 0, 2'b00));

    // reset state with live inputs, including a stray response
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", 64'(mem_req_o), 64'(0));
    chk("rst_gnt", 64'(gnt_o), 64'(0));
    chk("rst_rvalid", 64'(rvalid_o), 64'(0));
    chk("rst_grant_cnt", grant_cnt_o, 64'(0));
    @(negedge clk);
    rst_ni = 1'b1; req_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);
    chk_cnt("grant_cnt");

    // reset with one transaction outstanding for requester 1
    apply(mk(2'b10, 1, 0, 32'h0, 1, 1, 2'b10));
    @(negedge clk);
    #2;
    rst_ni = 1'b0; req_i = 2'b11; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD;
    #1;
    chk("midrst_mem_req", 64'(mem_req_o), 64'(0));
    chk("midrst_gnt", 64'(gnt_o), 64'(0));
    chk("midrst_rvalid", 64'(rvalid_o), 64'(0));
    chk("midrst_grant_cnt", grant_cnt_o, 64'(0));
    exp_q.delete();
    for (int unsigned r = 0; r < NR; r++) exp_cnt[r] = 0;
    @(negedge clk);
    #1;
    chk("midrst_rvalid_held", 64'(rvalid_o), 64'(0));
    rst_ni = 1'b1; req_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;

    // rr_ptr back at 0, FIFO empty: two grants fit, third stalls, old ID gone
    apply(mk(2'b11, 1, 0, 32'h0,  1, 0, 2'b01));
    apply(mk(2'b11, 1, 0, 32'h0,  1, 1, 2'b10));
    apply(mk(2'b11, 1, 0, 32'h0,  0, 0, 2'b00));
    apply(mk(2'b00, 0, 1, 32'h77, 0, 0, 2'b00));
    apply(mk(2'b00, 0, 1, 32'h88, 0, 0, 2'b00));
    chk_cnt("grant_cnt_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
